// File: rtl/fg_input_conditioner.sv
// Multi-channel input conditioner: per-channel synchronizer chain, debounce filter
// with a programmable stability length, and registered rise/fall strobes on the filtered level.
module fg_input_conditioner #(
  parameter int unsigned         CHANNELS   = 4,
  parameter int unsigned         STAGES     = 2,
  parameter int unsigned         FILTER_LEN = 4,
  parameter logic [CHANNELS-1:0] RST_VAL    = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] async_i,
  output logic [CHANNELS-1:0] sync_o,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
);

  localparam int unsigned     CntW   = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic [CHANNELS-1:0] r_sync [STAGES];
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CntW-1:0]     r_cnt [CHANNELS];

  logic [CHANNELS-1:0] w_sync;
  logic [CHANNELS-1:0] w_level_d;
  logic [CntW-1:0]     w_cnt_d [CHANNELS];

  assign w_sync = r_sync[STAGES-1];

  // Any cycle where the synchronized value agrees with the level restarts the count,
  // so only an unbroken run of FILTER_LEN mismatches moves the level.
  always_comb begin
    w_level_d = r_level;
    for (int k = 0; k < CHANNELS; k++) begin
      w_cnt_d[k] = '0;
      if (w_sync[k] != r_level[k]) begin
        if (r_cnt[k] == CntMax) begin
          w_level_d[k] = w_sync[k];
        end else begin
          w_cnt_d[k] = r_cnt[k] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= RST_VAL;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        r_cnt[k] <= '0;
      end
      r_level <= RST_VAL;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_sync[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      for (int k = 0; k < CHANNELS; k++) begin
        r_cnt[k] <= w_cnt_d[k];
      end
      r_level <= w_level_d;
      // Strobes are registered alongside the level so they coincide with its change.
      r_rise  <= w_level_d & ~r_level;
      r_fall  <= ~w_level_d & r_level;
    end
  end

  assign sync_o  = w_sync;
  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule

// File: tb/tb_fg_input_conditioner.sv
// Scoreboard bench for fg_input_conditioner: two configurations share stimulus; a window-based
// reference model pushes expected outputs per edge and a monitor pops and compares them.
module tb_fg_input_conditioner;

  localparam logic [3:0] RSTV = 4'b0001;
  localparam int         MAXE = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst     = 1'b1;
  logic [3:0]      async_v = 4'b0000;
  logic [1:0][3:0] sync_w, lev_w, rise_w, fall_w;

  fg_input_conditioner #(
    .CHANNELS(4), .STAGES(2), .FILTER_LEN(4), .RST_VAL(RSTV)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .async_i(async_v),
    .sync_o(sync_w[0]), .level_o(lev_w[0]), .rise_o(rise_w[0]), .fall_o(fall_w[0])
  );

  fg_input_conditioner #(
    .CHANNELS(4), .STAGES(3), .FILTER_LEN(1), .RST_VAL(RSTV)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .async_i(async_v),
    .sync_o(sync_w[1]), .level_o(lev_w[1]), .rise_o(rise_w[1]), .fall_o(fall_w[1])
  );

  typedef struct {
    int              n;
    logic [1:0][3:0] sync;
    logic [1:0][3:0] lev;
    logic [1:0][3:0] rise;
    logic [1:0][3:0] fall;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int   errors = 0;
  int   checks = 0;

  int         stg[2] = '{2, 3};
  int         flt[2] = '{4, 1};
  logic [3:0] a_hist[MAXE];
  bit         r_hist[MAXE];
  logic [3:0] lvl_hist[2][MAXE];
  int         last_rst = -1000;
  int         last_chg[2][4];
  int         n_edge = 0;

  int         rise_cnt[4];
  int         fall_cnt[4];
  int         rise3_edge = -1;
  int         fall3_edge = -1;
  int         lvlb_edge  = -1;
  logic       prev_lev_b0;

  task automatic chk(input string nm, input int c, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d edge %0d: got %b want %b", nm, c, n_edge, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Synchronized value seen after edge e: the input sampled STAGES-1 edges earlier,
  // or the reset value if any reset occurred within that window.
  function automatic logic [3:0] sync_at(input int c, input int e);
    for (int j = e - stg[c] + 1; j <= e; j++) begin
      if (j < 0 || r_hist[j]) return RSTV;
    end
    return a_hist[e - stg[c] + 1];
  endfunction

  // Level flips at edge n when the FILTER_LEN synchronized values preceding it all
  // differ from the level and none predate the last flip or reset of that channel.
  task automatic model_edge(input bit r, input logic [3:0] a);
    exp_t       e;
    int         n;
    int         base;
    bit         flip;
    logic       lv;
    logic       nl;
    logic [3:0] s;
    n = n_edge;
    if (n >= MAXE - 1) begin
      $display("FAIL model_overflow: got %0d want <%0d", n, MAXE - 1);
      $fatal(1);
    end
    a_hist[n] = a;
    r_hist[n] = r;
    e.n = n;
    if (r) last_rst = n;
    for (int c = 0; c < 2; c++) begin
      e.sync[c] = sync_at(c, n);
      e.rise[c] = 4'b0000;
      e.fall[c] = 4'b0000;
      if (r) begin
        lvl_hist[c][n] = RSTV;
      end else begin
        for (int k = 0; k < 4; k++) begin
          lv   = lvl_hist[c][n-1][k];
          base = (last_chg[c][k] > last_rst) ? last_chg[c][k] : last_rst;
          flip = (n - flt[c] >= base);
          for (int j = n - flt[c]; j < n && flip; j++) begin
            s = sync_at(c, j);
            if (s[k] == lv) flip = 1'b0;
          end
          nl = flip ? ~lv : lv;
          if (flip) last_chg[c][k] = n;
          lvl_hist[c][n][k] = nl;
          e.rise[c][k] = ~lv & nl;
          e.fall[c][k] = lv & ~nl;
        end
      end
      e.lev[c] = lvl_hist[c][n];
    end
    sb.push_back(e);
    n_edge++;
  endtask

  task automatic drive(input bit r, input logic [3:0] a);
    @(posedge clk);
    #2;
    rst     = r;
    async_v = a;
    model_edge(r, a);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon = sb.pop_front();
      for (int c = 0; c < 2; c++) begin
        chk("sync", c, sync_w[c], mon.sync[c]);
        chk("level", c, lev_w[c], mon.lev[c]);
        chk("rise", c, rise_w[c], mon.rise[c]);
        chk("fall", c, fall_w[c], mon.fall[c]);
      end
      for (int k = 0; k < 4; k++) begin
        if (rise_w[0][k] === 1'b1) rise_cnt[k]++;
        if (fall_w[0][k] === 1'b1) fall_cnt[k]++;
      end
      if (rise_w[0][3] === 1'b1) rise3_edge = mon.n;
      if (fall_w[0][3] === 1'b1) fall3_edge = mon.n;
      if (lev_w[1][0] !== prev_lev_b0) lvlb_edge = mon.n;
      prev_lev_b0 = lev_w[1][0];
    end
  end

  initial begin
    logic [3:0] a;
    logic [7:0] chat;
    int         rc;
    int         fc;
    int         t_app;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) last_chg[c][k] = -1000;
    end
    for (int k = 0; k < 4; k++) begin
      rise_cnt[k] = 0;
      fall_cnt[k] = 0;
    end

    // Reset with inputs opposite to the reset value on several channels.
    drive(1'b1, 4'b1010);
    drive(1'b1, 4'b1010);
    chk("rst_sync", 0, sync_w[0], 4'b0001);
    chk("rst_level", 0, lev_w[0], 4'b0001);
    chk("rst_rise", 0, rise_w[0], 4'b0000);
    chk("rst_fall", 0, fall_w[0], 4'b0000);
    drive(1'b1, 4'b1010);
    repeat (6) drive(1'b0, 4'b1010);
    chk("rel_edge5_level", 0, lev_w[0], 4'b0001);
    drive(1'b0, 4'b1010);
    chk("rel_edge6_level", 0, lev_w[0], 4'b1010);
    chk("rel_edge6_rise", 0, rise_w[0], 4'b1010);
    chk("rel_edge6_fall", 0, fall_w[0], 4'b0001);
    drive(1'b0, 4'b1010);
    chk("rel_edge7_rise", 0, rise_w[0], 4'b0000);
    chk("rel_edge7_fall", 0, fall_w[0], 4'b0000);
    repeat (6) drive(1'b0, 4'b1010);

    // Clean step on channel 2.
    repeat (2) drive(1'b0, 4'b1110);
    chk("step_sync1", 0, sync_w[0], 4'b1010);
    drive(1'b0, 4'b1110);
    chk("step_sync2", 0, sync_w[0], 4'b1110);
    repeat (3) drive(1'b0, 4'b1110);
    chk("step_lvl5", 0, lev_w[0], 4'b1010);
    drive(1'b0, 4'b1110);
    chk("step_lvl6", 0, lev_w[0], 4'b1110);
    chk("step_rise", 0, rise_w[0], 4'b0100);
    chk("step_fall", 0, fall_w[0], 4'b0000);
    drive(1'b0, 4'b1110);
    chk("step_rise_end", 0, rise_w[0], 4'b0000);

    // Glitch rejection on channel 3: 3-cycle pulse filtered, 4-cycle pulse passes.
    repeat (10) drive(1'b0, 4'b0110);
    rc = rise_cnt[3];
    fc = fall_cnt[3];
    repeat (3) drive(1'b0, 4'b1110);
    repeat (12) drive(1'b0, 4'b0110);
    chk_int("glitch3_rise", rise_cnt[3] - rc, 0);
    chk_int("glitch3_fall", fall_cnt[3] - fc, 0);
    chk("glitch3_level", 0, lev_w[0], 4'b0110);
    repeat (4) drive(1'b0, 4'b1110);
    repeat (12) drive(1'b0, 4'b0110);
    chk_int("glitch4_rise", rise_cnt[3] - rc, 1);
    chk_int("glitch4_fall", fall_cnt[3] - fc, 1);
    chk_int("glitch4_spacing", fall3_edge - rise3_edge, 4);

    // Chatter on channel 1: the single low sample restarts the count.
    repeat (10) drive(1'b0, 4'b0100);
    rc   = rise_cnt[1];
    chat = 8'b1111_0111;
    for (int i = 0; i < 8; i++) drive(1'b0, 4'b0100 | {2'b00, chat[i], 1'b0});
    repeat (10) drive(1'b0, 4'b0110);
    chk_int("chatter_rise", rise_cnt[1] - rc, 1);
    chk("chatter_level", 0, lev_w[0], 4'b0110);

    // Reset while channel 2 has a partial mismatch count.
    repeat (5) drive(1'b0, 4'b0010);
    drive(1'b1, 4'b0110);
    drive(1'b0, 4'b0110);
    chk("midrst_level", 0, lev_w[0], 4'b0001);
    chk("midrst_rise", 0, rise_w[0], 4'b0000);
    chk("midrst_fall", 0, fall_w[0], 4'b0000);
    drive(1'b0, 4'b0110);
    chk("midrst_next_rise", 0, rise_w[0], 4'b0000);
    chk("midrst_next_fall", 0, fall_w[0], 4'b0000);
    repeat (10) drive(1'b0, 4'b0110);

    // Randomized traffic with occasional resets.
    a = 4'b0110;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 5) == 0) a[k] = ~a[k];
      end
      drive($urandom_range(0, 59) == 0, a);
    end
    repeat (10) drive(1'b0, a);

    // Channel 0 toggling every 5 cycles: the STAGES=3, FILTER_LEN=1 instance lags by 4 edges.
    for (int t = 0; t < 8; t++) begin
      a[0]  = ~a[0];
      t_app = n_edge;
      repeat (5) drive(1'b0, a);
      chk_int("lagB", lvlb_edge - t_app, 3);
    end

    drive(1'b0, a);
    @(posedge clk);
    #3;
    chk_int("drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
